// File: rtl/ceil_div_serial.sv
// Run-time ceiling divider: quotient = ceil(dividend / divisor), computed by a
// bit-serial restoring divider (one quotient bit per cycle) behind valid/ready
// handshakes on both the operand and the result side.
module ceil_div_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             exact_o,
    output logic             div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Round the floor quotient up by one whenever a remainder is left over.
    // Cannot overflow: divisor >= 1 keeps the ceiling at or below the dividend.
    function automatic logic [WIDTH-1:0] ceil_round(input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] r);
        return q + {{(WIDTH-1){1'b0}}, (r != '0)};
    endfunction

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    // Trial subtraction one bit wider than the operands, so the bit shifted out
    // of a partial remainder with its MSB set is not lost.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr};
        fits      = ~trial[WIDTH];
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid_i) state_nxt = (divisor_i == '0) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ADJ;
            ADJ:  state_nxt = DONE;
            DONE: if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, one restoring-division step per CALC cycle,
    // and the result registers loaded in ADJ (or directly for a zero divisor).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            exact_o     <= 1'b0;
            div_zero_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        dvsr <= divisor_i;
                        quo  <= dividend_i;
                        rem  <= '0;
                        cnt  <= '0;
                        if (divisor_i == '0) begin
                            quotient_o  <= '1;
                            remainder_o <= '0;
                            exact_o     <= 1'b0;
                            div_zero_o  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                end
                ADJ: begin
                    quotient_o  <= ceil_round(quo, rem);
                    remainder_o <= rem;
                    exact_o     <= (rem == '0);
                    div_zero_o  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ceil_div_serial.sv
// Scoreboard bench for ceil_div_serial: the driver pushes the expected result
// of each accepted operation, a negedge monitor compares whatever the DUT
// presents against the oldest entry and retires it on the output handshake.
module tb_ceil_div_serial;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ex;
        logic         dz;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         exact;
    logic         div_zero;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic rand_rdy   = 1'b0;

    ceil_div_serial #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .exact_o     (exact),
        .div_zero_o  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic fail_note(input string name);
        total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: ceiling via (a + b - 1) / b in 64-bit arithmetic, remainder a % b.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t m;
        longint unsigned la, lb;
        m.acc = acc;
        if (b == 0) begin
            m.q  = '1;
            m.r  = '0;
            m.ex = 1'b0;
            m.dz = 1'b1;
        end else begin
            la   = 64'(a);
            lb   = 64'(b);
            m.q  = W'((la + lb - 1) / lb);
            m.r  = W'(la % lb);
            m.ex = (m.r == 0);
            m.dz = 1'b0;
        end
        return m;
    endfunction

    // Called just after a rising edge. Returns just after the accepting edge,
    // with the operand inputs scrambled to show they are no longer sampled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard    = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) begin
            fail_note("accept_timeout");
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(a, b, cyc + 1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
        end
    endtask

    // Wait for every outstanding result to be retired; ends just after a rising edge.
    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) fail_note("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare presented results against the oldest expectation every
    // valid cycle (which also proves stability under backpressure).
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) chk("valid_held", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (!prev_valid) rise_cyc = cyc;
                if (sb.size() == 0) begin
                    fail_note("spurious_output");
                end else begin
                    chk("quotient", 64'(quotient), 64'(sb[0].q));
                    chk("remainder", 64'(remainder), 64'(sb[0].r));
                    chk("exact", 64'(exact), 64'(sb[0].ex));
                    chk("div_zero", 64'(div_zero), 64'(sb[0].dz));
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                    // Edges from the accept edge to the edge that raised out_valid:
                    // WIDTH+1 for a real division; for a zero divisor the accept
                    // edge itself raises it, so the result is visible the cycle after.
                    if (!prev_valid)
                        chk("latency", 64'(rise_cyc - sb[0].acc), sb[0].dz ? 64'd0 : 64'(W + 1));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
        end
    end

    // Random result-side backpressure while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int guard;
        logic [W-1:0] a, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_exact", 64'(exact), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        @(posedge clk);
        #1;

        // Directed cases, consumer always ready.
        issue(32'd7, 32'd2);                    drain();
        issue(32'd8, 32'd2);                    drain();
        issue(32'd0, 32'd5);                    drain();
        issue(32'd5, 32'd0);                    drain();
        issue(32'hFFFF_FFFF, 32'd1);            drain();
        issue(32'd1, 32'hFFFF_FFFF);            drain();
        issue(32'hFFFF_FFFF, 32'h8000_0000);    drain();

        // Backpressure: hold the result of 100/7 for 10 cycles.
        out_ready = 1'b0;
        issue(32'd100, 32'd7);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) fail_note("bp_valid_timeout");
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_quotient", 64'(quotient), 64'd15);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_handshake", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC discards the operation.
        issue(32'd50, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(32'd9, 32'd4);
        drain();

        // Randomised operands with random result backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 16));
                2:       b = W'(1) << $urandom_range(0, W - 1);
                3:       b = '1;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                2:       a = W'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            issue(a, b);
        end
        rand_rdy  = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
